// File: rtl/isqrt_seq.sv
// rtl/isqrt_seq.sv - sequential integer square root, one result bit per cycle
// Restoring digit-by-digit method: two radicand bits are consumed per iteration.
module isqrt_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y,
  output logic        busy,
  output logic        x_drop
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic        take;
  logic [31:0] x_reg;
  logic [15:0] root;
  logic [17:0] rem;
  logic [3:0]  cnt;

  logic [19:0] rem_sh;
  logic [19:0] trial;
  logic [17:0] diff;
  logic        fit;
  logic [15:0] root_nxt;
  logic [17:0] rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (x_vld) begin
          take      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        take      = x_vld;
        state_nxt = x_vld ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The true difference fits in 18 bits whenever it is kept, so modular 18-bit subtraction suffices.
  always_comb begin
    rem_sh   = {rem, x_reg[31:30]};
    trial    = {2'b00, root, 2'b01};
    fit      = (rem_sh >= trial);
    diff     = rem_sh[17:0] - trial[17:0];
    root_nxt = {root[14:0], fit};
    rem_nxt  = fit ? diff : rem_sh[17:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg  <= '0;
      root   <= '0;
      rem    <= '0;
      cnt    <= '0;
      y      <= '0;
      y_vld  <= 1'b0;
      x_drop <= 1'b0;
    end else begin
      y_vld  <= 1'b0;
      x_drop <= (state == CALC) && x_vld;
      if (take) begin
        x_reg <= x;
        root  <= '0;
        rem   <= '0;
        cnt   <= '0;
      end else if (state == CALC) begin
        x_reg <= {x_reg[29:0], 2'b00};
        root  <= root_nxt;
        rem   <= rem_nxt;
        cnt   <= cnt + 4'd1;
        if (cnt == 4'd15) begin
          y     <= root_nxt;
          y_vld <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == CALC);

endmodule

// File: tb/tb_isqrt_seq.sv
// tb/tb_isqrt_seq.sv - self-checking bench for isqrt_seq
// Expected roots and arrival cycles are queued at request time and matched on y_vld.
module tb_isqrt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;
  logic        busy;
  logic        x_drop;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] y_prev   = '0;
  logic [15:0] exp_y_q[$];
  int          exp_cyc_q[$];

  isqrt_seq dut (
    .clk    (clk),
    .rst    (rst),
    .x_vld  (x_vld),
    .x      (x),
    .y_vld  (y_vld),
    .y      (y),
    .busy   (busy),
    .x_drop (x_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] isqrt_ref(input logic [31:0] v);
    longint lo = 0;
    longint hi = 65535;
    longint mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  // Scoreboard: every y_vld must match the oldest outstanding request, in value and cycle.
  always @(negedge clk) begin
    if (busy) check("y_hold", y, y_prev);
    if (y_vld) begin
      if (exp_y_q.size() == 0) begin
        check("extra_y_vld", 1, 0);
      end else begin
        check("y", y, exp_y_q.pop_front());
        check("latency", cyc, exp_cyc_q.pop_front());
      end
    end
    y_prev = y;
  end

  task automatic issue_now(input logic [31:0] v, input logic [15:0] e);
    x_vld = 1'b1;
    x     = v;
    exp_y_q.push_back(e);
    exp_cyc_q.push_back(cyc + 17);
    @(negedge clk);
    x_vld = 1'b0;
    x     = $urandom;
  endtask

  task automatic send(input logic [31:0] v, input logic [15:0] e);
    @(negedge clk);
    issue_now(v, e);
  endtask

  task automatic wait_yvld();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!y_vld && n < 40);
    check("y_vld_timeout", y_vld, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_y_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_y_q.size(), 0);
  endtask

  function automatic logic [31:0] gen(input int i);
    longint k;
    k = $urandom_range(1, 65535);
    case (i % 3)
      0:       return 32'(k * k);
      1:       return 32'(k * k - 1);
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] dir_x [8] = '{32'd0, 32'd1, 32'd15, 32'd16, 32'd17,
                              32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000};
  logic [15:0] dir_y [8] = '{16'd0, 16'd1, 16'd3, 16'd4, 16'd4,
                              16'hFFFF, 16'hFFFF, 16'hFFFE};

  initial begin
    logic [31:0] v;
    rst   = 1'b1;
    x_vld = 1'b1;
    x     = 32'd16;
    repeat (3) @(negedge clk);
    check("reset_y_vld", y_vld, 0);
    check("reset_y", y, 0);
    check("reset_busy", busy, 0);
    check("reset_x_drop", x_drop, 0);
    rst   = 1'b0;
    x_vld = 1'b0;
    @(negedge clk);
    check("post_reset_busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      send(dir_x[i], dir_y[i]);
      drain();
    end

    send(32'd100, 16'd10);
    wait_yvld();
    issue_now(32'd49, 16'd7);
    check("b2b_busy", busy, 1);
    drain();

    send(32'd81, 16'd9);
    repeat (4) @(negedge clk);
    x_vld = 1'b1;
    x     = 32'd4;
    @(negedge clk);
    x_vld = 1'b0;
    check("x_drop_pulse", x_drop, 1);
    @(negedge clk);
    check("x_drop_clear", x_drop, 0);
    drain();
    repeat (20) @(negedge clk);

    @(negedge clk);
    x_vld = 1'b1;
    x     = 32'd1000;
    @(negedge clk);
    x_vld = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_y", y, 0);
    check("abort_busy", busy, 0);
    repeat (20) @(negedge clk);
    send(32'd25, 16'd5);
    drain();

    v = gen(0);
    send(v, isqrt_ref(v));
    for (int i = 1; i < 2400; i++) begin
      v = gen(i);
      wait_yvld();
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue_now(v, isqrt_ref(v));
    end
    drain();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
